// File: rtl/minicpu_seq_ctrl.sv
// minicpu_seq_ctrl: multicycle fetch/decode/execute sequencer for the MiniCPU two-register datapath.
// Defining MINICPU_STEP_EN adds the step input and a PAUSE state after every non-HLT EXEC.
module minicpu_seq_ctrl #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef MINICPU_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [7:0]        imem_rdata,
  input  logic              a_zero,
  output logic              we_a,
  output logic              we_b,
  output logic [1:0]        data_sel,
  output logic              alu_op,
  output logic [7:0]        imm,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
`ifdef MINICPU_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDA  = 3'd1,
    OP_LDB  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_MOVB = 3'd5,
    OP_JNZ  = 3'd6,
    OP_HLT  = 3'd7
  } opcode_t;

`ifdef MINICPU_STEP_EN
  localparam state_t S_AFTER_EXEC = S_PAUSE;
`else
  localparam state_t S_AFTER_EXEC = S_FETCH;
`endif

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [7:0]        tmo_cnt;
  opcode_t           op;

  assign op = opcode_t'(ir[7:5]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_FAULT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            tmo_cnt <= '0;
          end
        end
        S_FETCH: begin
          // a response on the limit cycle still wins over the timeout
          if (imem_valid) begin
            ir      <= imem_rdata;
            tmo_cnt <= '0;
            state   <= S_EXEC;
          end else if (tmo_cnt == TMO_LIMIT) begin
            tmo_cnt <= '0;
            state   <= S_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          if (op == OP_HLT) begin
            state <= S_HALT;
          end else begin
            state <= S_AFTER_EXEC;
            if (op == OP_JNZ && !a_zero) pc <= ir[ADDR_W-1:0];
            else                         pc <= pc + ADDR_W'(1);
          end
        end
`ifdef MINICPU_STEP_EN
        S_PAUSE: begin
          if (step) state <= S_FETCH;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath controls decode straight from state so an async reset drops them at once.
  always_comb begin
    we_a     = 1'b0;
    we_b     = 1'b0;
    data_sel = 2'b00;
    alu_op   = 1'b0;
    imm      = '0;
    if (state == S_EXEC) begin
      imm = {3'b000, ir[4:0]};
      case (op)
        OP_LDA:  we_a = 1'b1;
        OP_LDB:  we_b = 1'b1;
        OP_ADD: begin
          we_a     = 1'b1;
          data_sel = 2'b01;
        end
        OP_SUB: begin
          we_a     = 1'b1;
          data_sel = 2'b01;
          alu_op   = 1'b1;
        end
        OP_MOVB: begin
          we_b     = 1'b1;
          data_sel = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign fault     = (state == S_FAULT);
`ifdef MINICPU_STEP_EN
  assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_PAUSE);
`else
  assign busy      = (state == S_FETCH) || (state == S_EXEC);
`endif

endmodule
